// File: rtl/alp_issue_pkg.sv
// Shared definitions for the ALP command issue stage: FSM encoding, opcodes, default widths.
package alp_issue_pkg;

  localparam int unsigned W_DEF = 4;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ABORT   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;

endpackage

// File: rtl/alp_cmd_fifo.sv
// Command FIFO: DEPTH entries of {op, a, b}; pointers carry one wrap bit for full/empty.
module alp_cmd_fifo
  import alp_issue_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  push,
  input  logic                  pop,
  input  logic [OP_W+2*W-1:0]   wdata,
  output logic [OP_W+2*W-1:0]   rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DW = OP_W + 2 * W;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alp_issue_unit.sv
// Issue stage ahead of the ALP controller: buffers commands, sequences LOAD/COMP,
// captures the result on done (Ready low), releases the controller, and aborts on watchdog expiry.
module alp_issue_unit
  import alp_issue_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [W-1:0]    cmd_a,
  input  logic [W-1:0]    cmd_b,
  output logic            LOAD,
  output logic            COMP,
  output logic [OP_W-1:0] OP,
  output logic [W-1:0]    DataA,
  output logic [W-1:0]    DataB,
  output logic            CtlCLR,
  input  logic            Ready,
  input  logic            ERR,
  input  logic [W-1:0]    R0,
  input  logic [W-1:0]    R1,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [W-1:0]    res_hi,
  output logic [W-1:0]    res_lo,
  output logic [OP_W-1:0] res_op,
  output logic            res_err,
  output logic            res_timeout
);

  localparam int unsigned DW  = OP_W + 2 * W;
  localparam int unsigned WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [OP_W-1:0] iss_op;
  logic [W-1:0]    iss_a;
  logic [W-1:0]    iss_b;
  logic [WDW-1:0]  wd_cnt;

  assign cmd_ready = !fifo_full;
  assign OP        = iss_op;

  alp_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .CLR   (CLR),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and controller strobes; strobes depend on state and issue register only.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    LOAD     = 1'b0;
    COMP     = 1'b0;
    CtlCLR   = 1'b0;
    DataA    = '0;
    DataB    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !res_valid) begin
          state_nx = ST_LOAD;
          fifo_pop = 1'b1;
        end
      end
      ST_LOAD: begin
        LOAD     = 1'b1;
        DataA    = iss_a;
        DataB    = iss_b;
        state_nx = ST_START;
      end
      ST_START: begin
        COMP     = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!Ready)                 state_nx = ST_RELEASE;
        else if (wd_cnt == WD_LAST) state_nx = ST_ABORT;
      end
      ST_ABORT: begin
        CtlCLR   = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_RELEASE: begin
        LOAD     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      iss_op <= OP_ADD;
      iss_a  <= '0;
      iss_b  <= '0;
    end else if (fifo_pop) begin
      {iss_op, iss_a, iss_b} <= fifo_rdata;
    end
  end

  // Watchdog saturates at its last value; expiry is handled by the FSM.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                                    wd_cnt <= '0;
    else if (state == ST_START)                 wd_cnt <= '0;
    else if (state == ST_WAIT && wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WDW'(1);
  end

  // A result is only produced while res_valid is low, so capture never collides with accept.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      res_valid   <= 1'b0;
      res_hi      <= '0;
      res_lo      <= '0;
      res_op      <= '0;
      res_err     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (state == ST_WAIT && !Ready) begin
        res_valid   <= 1'b1;
        res_hi      <= R1;
        res_lo      <= R0;
        res_op      <= iss_op;
        res_err     <= ERR;
        res_timeout <= 1'b0;
      end else if (state == ST_ABORT) begin
        res_valid   <= 1'b1;
        res_hi      <= '0;
        res_lo      <= '0;
        res_op      <= iss_op;
        res_err     <= 1'b1;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule
